seconds_counter: RTL and testbench

- Modulo-60 seconds counter for the clock/timekeeping datapath.
- Advances by one on every clock edge where `enable` is high.
- On the 59→0 wrap it emits a one-cycle `tick_minute` pulse to cascade into a minutes counter.
- The upstream prescaler, or a TB tying `enable` high, defines the "second" rate; this block counts qualified clock edges only.

---
 rtl/seconds_counter_pkg.sv | 9 +
 rtl/seconds_counter.sv | 64 ++++++
 tb/tb_seconds_counter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seconds_counter_pkg.sv
// Shared timekeeping definitions used by the seconds/minutes/hours counters.
package seconds_counter_pkg;

    localparam int SEC_WIDTH = 6;
    localparam int SEC_MAX   = 59;

    typedef logic [SEC_WIDTH-1:0] sec_t;

endpackage : seconds_counter_pkg

// File: rtl/seconds_counter.sv
// Modulo-60 seconds counter with a one-cycle minute tick on the 59->0 wrap.
// Optional synchronous preload is enabled with the macro SECONDS_COUNTER_LOAD_EN.
module seconds_counter
    import seconds_counter_pkg::*;
#(
    parameter int WIDTH     = SEC_WIDTH,
    parameter int MAX_COUNT = SEC_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
`ifdef SECONDS_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] seconds,
    output logic             tick_minute
);

    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_seconds;
    logic             r_tick;
    logic [WIDTH-1:0] w_seconds_nxt;
    logic             w_tick_nxt;

    // Next count and tick: hold by default, advance/wrap on enable, load overrides enable.
    always_comb begin
        w_seconds_nxt = r_seconds;
        w_tick_nxt    = 1'b0;
        if (enable) begin
            if (r_seconds == L_MAX) begin
                w_seconds_nxt = '0;
                w_tick_nxt    = 1'b1;
            end else if (r_seconds > L_MAX) begin
                // Corrupted state recovers to zero without claiming a minute.
                w_seconds_nxt = '0;
            end else begin
                w_seconds_nxt = r_seconds + 1'b1;
            end
        end
`ifdef SECONDS_COUNTER_LOAD_EN
        if (load) begin
            w_seconds_nxt = (load_value <= L_MAX) ? load_value : '0;
            w_tick_nxt    = 1'b0;
        end
`endif
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seconds <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_seconds <= w_seconds_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign seconds     = r_seconds;
    assign tick_minute = r_tick;

endmodule : seconds_counter

// File: tb/tb_seconds_counter.sv
// Self-checking bench for seconds_counter: directed scenarios plus random
// enable/reset (and load when SECONDS_COUNTER_LOAD_EN is defined) against
// an arithmetic reference model.
module tb_seconds_counter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [5:0] load_value;
    logic [5:0] seconds;
    logic       tick_minute;

    int checks;
    int errors;
    int m_sec;
    int m_tick;
    int tick_seen;

    seconds_counter #(.WIDTH(6), .MAX_COUNT(59)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef SECONDS_COUNTER_LOAD_EN
        .load        (load),
        .load_value  (load_value),
`endif
        .seconds     (seconds),
        .tick_minute (tick_minute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one edge, advance the model, then compare both outputs.
    task automatic do_edge(input logic rn, input logic en, input logic ld, input int lv);
        rst_n      = rn;
        enable     = en;
        load       = ld;
        load_value = 6'(lv);
        @(posedge clk);
        if (!rn) begin
            m_sec  = 0;
            m_tick = 0;
        end else if (ld) begin
            m_sec  = (lv <= 59) ? lv : 0;
            m_tick = 0;
        end else if (en) begin
            m_tick = (m_sec == 59) ? 1 : 0;
            m_sec  = (m_sec + 1) % 60;
        end else begin
            m_tick = 0;
        end
        #1;
        if (tick_minute === 1'b1) tick_seen++;
        check_val("seconds", int'(seconds), m_sec);
        check_val("tick_minute", int'(tick_minute), m_tick);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_sec      = 0;
        m_tick     = 0;
        tick_seen  = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = '0;

        // Reset for two edges, then one idle edge.
        do_edge(1'b0, 1'b0, 1'b0, 0);
        do_edge(1'b0, 1'b0, 1'b0, 0);
        do_edge(1'b1, 1'b0, 1'b0, 0);
        check_val("idle_after_reset", int'(seconds), 0);

        // 70 continuous enabled edges: exactly one tick, ends at 10.
        tick_seen = 0;
        for (int i = 0; i < 70; i++) do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("sec_after_70", int'(seconds), 10);
        check_val("ticks_in_70", tick_seen, 1);

        // Pause at 10 for 5 edges, resume for 10.
        for (int i = 0; i < 5; i++) do_edge(1'b1, 1'b0, 1'b0, 0);
        check_val("paused_at_10", int'(seconds), 10);
        for (int i = 0; i < 10; i++) do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("resumed_to_20", int'(seconds), 20);

        // Boundary: hold at 59 without a tick, then wrap with a single tick.
        for (int i = 0; i < 39; i++) do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("reached_59", int'(seconds), 59);
        tick_seen = 0;
        for (int i = 0; i < 3; i++) do_edge(1'b1, 1'b0, 1'b0, 0);
        check_val("no_tick_while_held", tick_seen, 0);
        do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("wrap_tick", int'(tick_minute), 1);
        do_edge(1'b1, 1'b0, 1'b0, 0);
        check_val("tick_one_cycle", tick_seen, 1);

        // Reset mid-count at 37 while enabled, then resume 0,1,2.
        for (int i = 0; i < 37; i++) do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("at_37", int'(seconds), 37);
        do_edge(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("resume_after_reset", int'(seconds), 3);

`ifdef SECONDS_COUNTER_LOAD_EN
        // Load 58, then count through the wrap.
        do_edge(1'b1, 1'b0, 1'b1, 58);
        do_edge(1'b1, 1'b1, 1'b0, 0);
        do_edge(1'b1, 1'b1, 1'b0, 0);
        check_val("load58_wrap_tick", int'(tick_minute), 1);
        // Out-of-range load goes to zero without a tick.
        do_edge(1'b1, 1'b1, 1'b0, 0);
        do_edge(1'b1, 1'b0, 1'b1, 63);
        check_val("load63_zero", int'(seconds), 0);
        // Load wins over enable.
        do_edge(1'b1, 1'b1, 1'b1, 5);
        check_val("load_beats_enable", int'(seconds), 5);
`endif

        // Randomized enable, occasional reset (and load when present).
        for (int i = 0; i < 600; i++) begin
            logic rn;
            logic en;
            logic ld;
            int   lv;
            rn = ($urandom_range(0, 39) != 0);
            en = ($urandom_range(0, 3) != 0);
`ifdef SECONDS_COUNTER_LOAD_EN
            ld = ($urandom_range(0, 19) == 0);
            lv = int'($urandom_range(0, 63));
`else
            ld = 1'b0;
            lv = 0;
`endif
            do_edge(rn, en, ld, lv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seconds_counter
